cu_multicycle_param: RTL

- Parametrised successor to the current 16-bit multi-cycle control unit. It sequences FETCH/DECODE/EXEC/MEM/WB over the existing memory, register-file and ALU blocks.
- Generalised data width, register count and address width.
- New versus the current generation: variable-latency memory handshake (Mem_Ready), conditional branch (BEQ), HALT instruction with a Halted status output.
- Sits between the top-level datapath wiring and the memory, RF and ALU instances.

---
 rtl/cu_pkg.sv | 25 ++
 rtl/cu_decode.sv | 27 ++
 rtl/cu_multicycle_param.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared types and encodings for the parametrised multi-cycle control unit.
package cu_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  // R-type opcodes occupy the lower half of the opcode space.
  function automatic logic is_rtype(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Instruction field extractor: opcode, register indices and sign-extended offset.
module cu_decode #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 2,
  parameter int ADDR_W = 16
) (
  input  logic [DATA_W-1:0] ir,
  output logic [2:0]        opcode,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [ADDR_W-1:0] off
);

  localparam int OFF_W = DATA_W - 3 - 2*REG_AW;

  logic signed [OFF_W-1:0] off_raw;

  assign opcode  = ir[DATA_W-1 -: 3];
  assign rd      = ir[DATA_W-4 -: REG_AW];
  assign rs1     = ir[DATA_W-4-REG_AW -: REG_AW];
  // rs2 shares its bits with the top of the offset field.
  assign rs2     = ir[OFF_W-1 -: REG_AW];
  assign off_raw = ir[OFF_W-1:0];
  assign off     = ADDR_W'(off_raw);

endmodule

// File: rtl/cu_multicycle_param.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with handshaked memory and ALU.
module cu_multicycle_param
  import cu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 2,
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic              Mem_Read_Enable,
  output logic              Mem_Write_Enable,
  output logic [DATA_W-1:0] Mem_Write_Data,
  input  logic [DATA_W-1:0] Mem_Read_Data,
  input  logic              Mem_Ready,
  output logic              RF_Write_Enable,
  output logic [REG_AW-1:0] RF_Write_Address,
  output logic [DATA_W-1:0] RF_Write_Data,
  output logic [REG_AW-1:0] RF_Read_Address1,
  output logic [REG_AW-1:0] RF_Read_Address2,
  input  logic [DATA_W-1:0] RF_Read_Data1,
  input  logic [DATA_W-1:0] RF_Read_Data2,
  output logic [1:0]        ALUOP,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic              ALU_Start,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic              ALU_Done,
  output logic              Halted,
  output logic [ADDR_W-1:0] PC_Out
);

  state_t            state, state_nx;
  logic [DATA_W-1:0] ir, base_q, opb_q, wb_q;
  logic [ADDR_W-1:0] pc, off_q, addr_q, pc_inc;
  logic [2:0]        opcode;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [ADDR_W-1:0] off;
  logic              rtype;

  cu_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ADDR_W(ADDR_W)) u_decode (
    .ir(ir), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .off(off)
  );

  assign rtype  = is_rtype(opcode);
  assign pc_inc = pc + ADDR_W'(1);
  assign PC_Out = pc;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      base_q <= '0;
      opb_q  <= '0;
      off_q  <= '0;
      addr_q <= '0;
      wb_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        FETCH:  if (Mem_Ready) ir <= Mem_Read_Data;
        // opb_q holds R[rs2] for R-type, otherwise R[rd] (store data / BEQ compare).
        DECODE: begin
          base_q <= RF_Read_Data1;
          opb_q  <= RF_Read_Data2;
          off_q  <= off;
        end
        EXEC: begin
          if (rtype) begin
            if (ALU_Done) wb_q <= ALU_Result;
          end else if (opcode == OP_BEQ) begin
            pc <= (opb_q == base_q) ? pc_inc + off_q : pc_inc;
          end else begin
            addr_q <= ADDR_W'(base_q) + off_q;
          end
        end
        MEM: begin
          if (Mem_Ready) begin
            if (opcode == OP_LOAD) wb_q <= Mem_Read_Data;
            else                   pc   <= pc_inc;
          end
        end
        WB:      pc <= pc_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx         = state;
    Mem_Address      = '0;
    Mem_Read_Enable  = 1'b0;
    Mem_Write_Enable = 1'b0;
    Mem_Write_Data   = '0;
    RF_Write_Enable  = 1'b0;
    RF_Write_Address = '0;
    RF_Write_Data    = '0;
    RF_Read_Address1 = '0;
    RF_Read_Address2 = '0;
    ALUOP            = '0;
    ALU_A            = '0;
    ALU_B            = '0;
    ALU_Start        = 1'b0;
    Halted           = 1'b0;
    case (state)
      FETCH: begin
        Mem_Address     = pc;
        Mem_Read_Enable = 1'b1;
        if (Mem_Ready) state_nx = DECODE;
      end
      DECODE: begin
        RF_Read_Address1 = rs1;
        RF_Read_Address2 = rtype ? rs2 : rd;
        state_nx         = (opcode == OP_HALT) ? HALT : EXEC;
      end
      EXEC: begin
        if (rtype) begin
          ALU_Start = 1'b1;
          ALUOP     = opcode[1:0];
          ALU_A     = base_q;
          ALU_B     = opb_q;
          if (ALU_Done) state_nx = WB;
        end else if (opcode == OP_BEQ) begin
          state_nx = FETCH;
        end else begin
          state_nx = MEM;
        end
      end
      MEM: begin
        Mem_Address = addr_q;
        if (opcode == OP_LOAD) begin
          Mem_Read_Enable = 1'b1;
          if (Mem_Ready) state_nx = WB;
        end else begin
          Mem_Write_Enable = 1'b1;
          Mem_Write_Data   = opb_q;
          if (Mem_Ready) state_nx = FETCH;
        end
      end
      WB: begin
        RF_Write_Enable  = 1'b1;
        RF_Write_Address = rd;
        RF_Write_Data    = wb_q;
        state_nx         = FETCH;
      end
      HALT:    Halted = 1'b1;
      default: state_nx = FETCH;
    endcase
  end

endmodule
